// File: rtl/cmp_share_arbiter.sv
// Round-robin front end that time-shares one pipelined 6-bit comparator among NREQ clients.
// Operands issue at S0, mode follows one stage later, and results return tagged to their issuer.
module cmp_share_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [6*NREQ-1:0] req_a,
   input  logic [6*NREQ-1:0] req_b,
   input  logic [NREQ-1:0]   req_sel,
   output logic [5:0]        cmp_A,
   output logic [5:0]        cmp_B,
   output logic              cmp_sel,
   input  logic              cmp_E,
   input  logic              cmp_G,
   input  logic              cmp_S,
   output logic [NREQ-1:0]   rsp_valid,
   output logic              rsp_E,
   output logic              rsp_G,
   output logic              rsp_S,
   output logic              busy,
   output logic [15:0]       issue_cnt
);

   localparam int W = 6;

   function automatic int wrap_idx(input int base, input int off);
      int sum;
      sum = base + off;
      if (sum >= NREQ) begin
         sum = sum - NREQ;
      end
      return sum;
   endfunction

   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [W-1:0]    cmp_a_q, cmp_a_d;
   logic [W-1:0]    cmp_b_q, cmp_b_d;
   logic            sel0_q, sel0_d;
   logic [IDW-1:0]  id0_q, id0_d;
   logic            v0_q, v0_d;
   logic            cmp_sel_q, cmp_sel_d;
   logic [IDW-1:0]  id1_q, id1_d;
   logic            v1_q, v1_d;
   logic [IDW-1:0]  id2_q, id2_d;
   logic            v2_q, v2_d;
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
   logic            rsp_e_q, rsp_e_d;
   logic            rsp_g_q, rsp_g_d;
   logic            rsp_s_q, rsp_s_d;
   logic [15:0]     issue_cnt_q, issue_cnt_d;

   logic            grant_found;
   int              win_idx;
   logic [W-1:0]    win_a;
   logic [W-1:0]    win_b;
   logic            win_sel;
   logic            accept;

   // First valid requester at or after ptr wins; en only masks the grant, not the search.
   always_comb begin
      grant_found = 1'b0;
      win_idx     = 0;
      win_a       = '0;
      win_b       = '0;
      win_sel     = 1'b0;
      req_ready   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!grant_found && req_valid[wrap_idx(int'(ptr_q), k)]) begin
            grant_found = 1'b1;
            win_idx     = wrap_idx(int'(ptr_q), k);
         end
      end
      if (grant_found) begin
         win_a   = req_a[win_idx*W +: W];
         win_b   = req_b[win_idx*W +: W];
         win_sel = req_sel[win_idx];
         if (en) begin
            req_ready[win_idx] = 1'b1;
         end
      end
      accept = en && grant_found;
   end

   always_comb begin
      ptr_d       = ptr_q;
      cmp_a_d     = cmp_a_q;
      cmp_b_d     = cmp_b_q;
      sel0_d      = sel0_q;
      id0_d       = id0_q;
      v0_d        = accept;
      issue_cnt_d = issue_cnt_q;
      if (accept) begin
         ptr_d       = IDW'(wrap_idx(win_idx, 1));
         cmp_a_d     = win_a;
         cmp_b_d     = win_b;
         sel0_d      = win_sel;
         id0_d       = IDW'(win_idx);
         issue_cnt_d = issue_cnt_q + 16'd1;
      end

      // Mode lags operands by one stage to meet the comparator's input register.
      cmp_sel_d = v0_q ? sel0_q : cmp_sel_q;
      id1_d     = id0_q;
      v1_d      = v0_q;
      id2_d     = id1_q;
      v2_d      = v1_q;

      // Results are only sampled for live operations so the unreset comparator's X never leaks.
      rsp_e_d = rsp_e_q;
      rsp_g_d = rsp_g_q;
      rsp_s_d = rsp_s_q;
      if (v2_q) begin
         rsp_e_d = cmp_E;
         rsp_g_d = cmp_G;
         rsp_s_d = cmp_S;
      end
      rsp_valid_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         rsp_valid_d[i] = v2_q && (id2_q == IDW'(i));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q       <= '0;
         cmp_a_q     <= '0;
         cmp_b_q     <= '0;
         sel0_q      <= 1'b0;
         id0_q       <= '0;
         v0_q        <= 1'b0;
         cmp_sel_q   <= 1'b0;
         id1_q       <= '0;
         v1_q        <= 1'b0;
         id2_q       <= '0;
         v2_q        <= 1'b0;
         rsp_valid_q <= '0;
         rsp_e_q     <= 1'b0;
         rsp_g_q     <= 1'b0;
         rsp_s_q     <= 1'b0;
         issue_cnt_q <= '0;
      end else begin
         ptr_q       <= ptr_d;
         cmp_a_q     <= cmp_a_d;
         cmp_b_q     <= cmp_b_d;
         sel0_q      <= sel0_d;
         id0_q       <= id0_d;
         v0_q        <= v0_d;
         cmp_sel_q   <= cmp_sel_d;
         id1_q       <= id1_d;
         v1_q        <= v1_d;
         id2_q       <= id2_d;
         v2_q        <= v2_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_e_q     <= rsp_e_d;
         rsp_g_q     <= rsp_g_d;
         rsp_s_q     <= rsp_s_d;
         issue_cnt_q <= issue_cnt_d;
      end
   end

   assign cmp_A     = cmp_a_q;
   assign cmp_B     = cmp_b_q;
   assign cmp_sel   = cmp_sel_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_E     = rsp_e_q;
   assign rsp_G     = rsp_g_q;
   assign rsp_S     = rsp_s_q;
   assign issue_cnt = issue_cnt_q;
   assign busy      = v0_q | v1_q | v2_q | (|rsp_valid_q);

endmodule
